// File: rtl/cacheline_mem_arbiter.sv
// Shares one burst memory port between I-cache and D-cache.
// Lines move as BURST_LEN beats of BEAT_WIDTH bits, round-robin grant.
module cacheline_mem_arbiter #(
  parameter int BEAT_WIDTH = 64,
  parameter int BURST_LEN  = 4,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [31:0]           i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [31:0]           d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [31:0]           pmem_address,
  output logic [BEAT_WIDTH-1:0] pmem_wdata,
  input  logic [BEAT_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int CW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OFF = $clog2(LINE_WIDTH / 8);
  localparam int LW  = $clog2(LINE_WIDTH);
  localparam int BSH = $clog2(BEAT_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_I_RD,
    S_D_RD,
    S_D_WR,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_last_d;
  logic [31:0]           r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_i_rdata;
  logic [LINE_WIDTH-1:0] r_d_rdata;
  logic                  r_i_resp;
  logic                  r_d_resp;
  logic                  r_rd;
  logic                  r_wr;

  logic                  w_i_req;
  logic                  w_d_req;
  logic                  w_grant_d;
  logic                  w_last;
  logic [31:0]           w_line_addr;
  logic [LW-1:0]         w_base;
  logic                  w_unused;

  assign w_i_req   = i_read;
  assign w_d_req   = d_read | d_write;
  // D wins a tie unless it was the last side served
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);
  assign w_last    = pmem_resp & (r_cnt == LAST);
  assign w_base    = LW'({r_cnt, {BSH{1'b0}}});

  assign w_line_addr = {
    (w_grant_d ? d_address[31:OFF] : i_address[31:OFF]),
    {OFF{1'b0}}
  };

  // Byte offset inside a line is irrelevant to a line transfer
  assign w_unused = ^{i_address[OFF-1:0], d_address[OFF-1:0]};

  assign i_rdata      = r_i_rdata;
  assign d_rdata      = r_d_rdata;
  assign i_resp       = r_i_resp;
  assign d_resp       = r_d_resp;
  assign pmem_read    = r_rd;
  assign pmem_write   = r_wr;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata[w_base +: BEAT_WIDTH];

  // Grant, burst sequencing, beat capture and the resp pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last_d  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_resp  <= 1'b0;
      r_d_resp  <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_i_req || w_d_req) begin
            r_addr   <= w_line_addr;
            r_cnt    <= '0;
            r_last_d <= w_grant_d;
            if (w_grant_d && d_write) begin
              r_wdata <= d_wdata;
              r_wr    <= 1'b1;
              r_state <= S_D_WR;
            end else begin
              r_rd    <= 1'b1;
              r_state <= w_grant_d ? S_D_RD : S_I_RD;
            end
          end
        end
        S_I_RD, S_D_RD: begin
          if (pmem_resp) begin
            if (r_state == S_I_RD)
              r_i_rdata[w_base +: BEAT_WIDTH] <= pmem_rdata;
            else
              r_d_rdata[w_base +: BEAT_WIDTH] <= pmem_rdata;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_rd    <= 1'b0;
              r_state <= S_RESP;
              if (r_state == S_I_RD)
                r_i_resp <= 1'b1;
              else
                r_d_resp <= 1'b1;
            end
          end
        end
        S_D_WR: begin
          if (pmem_resp) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_wr     <= 1'b0;
              r_d_resp <= 1'b1;
              r_state  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          r_i_resp <= 1'b0;
          r_d_resp <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read and write together from the D-cache is a protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(d_read && d_write));
    end
  end

endmodule
